vga_display_engine: RTL and testbench

VGA_DISPLAY_ENGINE -- requirements
Module: vga_display_engine

---
 rtl/vga_display_engine.sv | 163 ++++++++++++++++
 tb/tb_vga_display_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_display_engine.sv
// VGA timing generator with a pixel request interface and a fixed-latency
// colour return path; syncs and colour are delayed together so they stay aligned.
module vga_display_engine #(
  parameter int   WIDTH_COLOR = 12,
  parameter int   WIDTH_POS   = 10,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   LATENCY     = 2
) (
  input  logic                       pixel_clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH_COLOR-1:0]     color,
  output logic                       req,
  output logic [WIDTH_POS-1:0]       xpos,
  output logic [WIDTH_POS-1:0]       ypos,
  output logic                       frame_start,
  output logic                       hsync,
  output logic                       vsync,
  output logic [WIDTH_COLOR/3-1:0]   red,
  output logic [WIDTH_COLOR/3-1:0]   green,
  output logic [WIDTH_COLOR/3-1:0]   blue
);

  localparam int CW      = WIDTH_COLOR / 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [WIDTH_POS-1:0] POS_ZERO = {WIDTH_POS{1'b0}};
  localparam logic [WIDTH_POS-1:0] H_LAST   = WIDTH_POS'(H_TOTAL - 1);
  localparam logic [WIDTH_POS-1:0] V_LAST   = WIDTH_POS'(V_TOTAL - 1);
  localparam logic [WIDTH_POS-1:0] H_ACT    = WIDTH_POS'(H_ACTIVE);
  localparam logic [WIDTH_POS-1:0] V_ACT    = WIDTH_POS'(V_ACTIVE);
  localparam logic [WIDTH_POS-1:0] HS_BEG   = WIDTH_POS'(H_ACTIVE + H_FP);
  localparam logic [WIDTH_POS-1:0] HS_END   = WIDTH_POS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [WIDTH_POS-1:0] VS_BEG   = WIDTH_POS'(V_ACTIVE + V_FP);
  localparam logic [WIDTH_POS-1:0] VS_END   = WIDTH_POS'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_OFF = ~HS_POL;
  localparam logic VS_OFF = ~VS_POL;
  localparam logic [CW-1:0] CH_ZERO = {CW{1'b0}};

  if (H_TOTAL >= (1 << WIDTH_POS)) begin : g_bad_h_total
    $error("H_TOTAL does not fit in WIDTH_POS bits");
  end
  if (V_TOTAL >= (1 << WIDTH_POS)) begin : g_bad_v_total
    $error("V_TOTAL does not fit in WIDTH_POS bits");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("LATENCY must be in 1..8");
  end
  if (CW * 3 != WIDTH_COLOR) begin : g_bad_color
    $error("WIDTH_COLOR must split into three equal channels");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state;
  logic [WIDTH_POS-1:0] h_cnt;
  logic [WIDTH_POS-1:0] v_cnt;
  logic                 run;
  logic                 raw_hs;
  logic                 raw_vs;
  logic [LATENCY-1:0]   hs_pipe;
  logic [LATENCY-1:0]   vs_pipe;
  logic [LATENCY-1:0]   act_pipe;

  // Start is accepted any time from IDLE; stop only on the last pixel of a frame.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state <= IDLE;
      h_cnt <= POS_ZERO;
      v_cnt <= POS_ZERO;
    end else begin
      case (state)
        IDLE: begin
          h_cnt <= POS_ZERO;
          v_cnt <= POS_ZERO;
          if (en) begin
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= POS_ZERO;
            if (v_cnt == V_LAST) begin
              v_cnt <= POS_ZERO;
              if (!en) begin
                state <= IDLE;
              end else begin
                state <= RUN;
              end
            end else begin
              v_cnt <= v_cnt + 1'b1;
            end
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          h_cnt <= POS_ZERO;
          v_cnt <= POS_ZERO;
        end
      endcase
    end
  end

  // Request side is decoded straight from the counter position.
  always_comb begin
    run         = (state == RUN);
    req         = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    xpos        = req ? h_cnt : POS_ZERO;
    ypos        = req ? v_cnt : POS_ZERO;
    frame_start = run && (h_cnt == POS_ZERO) && (v_cnt == POS_ZERO);
    raw_hs      = (run && (h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_POL : HS_OFF;
    raw_vs      = (run && (v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_POL : VS_OFF;
  end

  // Delay syncs and active by LATENCY, then one output register where colour joins.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hs_pipe  <= {LATENCY{HS_OFF}};
      vs_pipe  <= {LATENCY{VS_OFF}};
      act_pipe <= {LATENCY{1'b0}};
      hsync    <= HS_OFF;
      vsync    <= VS_OFF;
      red      <= CH_ZERO;
      green    <= CH_ZERO;
      blue     <= CH_ZERO;
    end else begin
      hs_pipe[0]  <= raw_hs;
      vs_pipe[0]  <= raw_vs;
      act_pipe[0] <= req;
      for (int i = 1; i < LATENCY; i++) begin
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        act_pipe[i] <= act_pipe[i-1];
      end
      hsync <= hs_pipe[LATENCY-1];
      vsync <= vs_pipe[LATENCY-1];
      if (act_pipe[LATENCY-1]) begin
        red   <= color[3*CW-1:2*CW];
        green <= color[2*CW-1:CW];
        blue  <= color[CW-1:0];
      end else begin
        red   <= CH_ZERO;
        green <= CH_ZERO;
        blue  <= CH_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_vga_display_engine.sv
// Bench for vga_display_engine: a default-timing instance and a tiny-timing
// instance (LATENCY=1, positive syncs), checked every cycle against a frame-index model.
module tb_vga_display_engine;

  localparam int LD = 2;
  localparam int LS = 1;
  localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  localparam int S_HA = 8,   S_HF = 2,  S_HS = 3,  S_HB = 2;
  localparam int S_VA = 4,   S_VF = 1,  S_VS = 2,  S_VB = 1;
  localparam int FRAME_D = (D_HA + D_HF + D_HS + D_HB) * (D_VA + D_VF + D_VS + D_VB);
  localparam int FRAME_S = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d = 1'b1, en_d = 1'b0;
  logic [11:0] color_d = 12'hFFF;
  logic        req_d, frame_start_d, hsync_d, vsync_d;
  logic [9:0]  xpos_d, ypos_d;
  logic [3:0]  red_d, green_d, blue_d;

  logic        rst_s = 1'b1, en_s = 1'b0;
  logic [11:0] color_s = 12'hFFF;
  logic        req_s, frame_start_s, hsync_s, vsync_s;
  logic [3:0]  xpos_s, ypos_s;
  logic [3:0]  red_s, green_s, blue_s;

  vga_display_engine dut_d (
    .pixel_clk(clk), .rst(rst_d), .en(en_d), .color(color_d),
    .req(req_d), .xpos(xpos_d), .ypos(ypos_d), .frame_start(frame_start_d),
    .hsync(hsync_d), .vsync(vsync_d), .red(red_d), .green(green_d), .blue(blue_d)
  );

  vga_display_engine #(
    .WIDTH_POS(4), .LATENCY(LS), .HS_POL(1'b1), .VS_POL(1'b1),
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_s (
    .pixel_clk(clk), .rst(rst_s), .en(en_s), .color(color_s),
    .req(req_s), .xpos(xpos_s), .ypos(ypos_s), .frame_start(frame_start_s),
    .hsync(hsync_s), .vsync(vsync_s), .red(red_s), .green(green_s), .blue(blue_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } raw_t;

  // What the undelayed outputs must be at frame index k.
  function automatic raw_t raw_at(input bit run, input int k, input int ha, input int hf,
                                  input int hs, input int hb, input int va, input int vf,
                                  input int vs, input bit pol);
    int   ht, h, v;
    raw_t r;
    ht     = ha + hf + hs + hb;
    h      = k % ht;
    v      = k / ht;
    r.act  = run && (h < ha) && (v < va);
    r.x    = r.act ? h[9:0] : 10'd0;
    r.y    = r.act ? v[9:0] : 10'd0;
    r.hs   = (run && h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
    r.vs   = (run && v >= va + vf && v < va + vf + vs) ? pol : !pol;
    r.fs   = run && (k == 0);
    return r;
  endfunction

  function automatic raw_t rd(input bit run, input int k);
    return raw_at(run, k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, 1'b0);
  endfunction

  function automatic raw_t rs(input bit run, input int k);
    return raw_at(run, k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, 1'b1);
  endfunction

  bit          run_d = 1'b0, run_s = 1'b0, chk_en = 1'b0;
  int          k_d = 0, k_s = 0;
  raw_t        qd[$];
  raw_t        qs[$];
  logic [11:0] exp_rgb_d = 12'h000, exp_rgb_s = 12'h000;

  // Model: advance at each edge, keep LATENCY+1 cycles of history, then drive colour.
  initial begin
    raw_t cur;
    raw_t dump;
    forever begin
      @(posedge clk);
      cur = rd(run_d, k_d);
      if (rst_d) begin
        qd.delete();
        for (int i = 0; i <= LD; i++) qd.push_back(rd(1'b0, 0));
        exp_rgb_d = 12'h000; run_d = 1'b0; k_d = 0; chk_en = 1'b1;
      end else begin
        qd.push_front(cur);
        while (qd.size() > LD + 1) dump = qd.pop_back();
        exp_rgb_d = qd[LD].act ? color_d : 12'h000;
        if (!run_d) begin
          if (en_d) begin run_d = 1'b1; k_d = 0; end
        end else if (k_d == FRAME_D - 1) begin
          k_d = 0;
          if (!en_d) run_d = 1'b0;
        end else begin
          k_d = k_d + 1;
        end
      end
      cur = rs(run_s, k_s);
      if (rst_s) begin
        qs.delete();
        for (int i = 0; i <= LS; i++) qs.push_back(rs(1'b0, 0));
        exp_rgb_s = 12'h000; run_s = 1'b0; k_s = 0;
      end else begin
        qs.push_front(cur);
        while (qs.size() > LS + 1) dump = qs.pop_back();
        exp_rgb_s = qs[LS].act ? color_s : 12'h000;
        if (!run_s) begin
          if (en_s) begin run_s = 1'b1; k_s = 0; end
        end else if (k_s == FRAME_S - 1) begin
          k_s = 0;
          if (!en_s) run_s = 1'b0;
        end else begin
          k_s = k_s + 1;
        end
      end
      #2;
      color_d = qd[LD-1].act ? {qd[LD-1].x[3:0], qd[LD-1].y[3:0], 4'h5} : 12'hFFF;
      color_s = 12'hFFF;
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    raw_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = rd(run_d, k_d);
        chk("d_req", req_d, e.act);
        chk("d_xpos", xpos_d, e.x);
        chk("d_ypos", ypos_d, e.y);
        chk("d_frame_start", frame_start_d, e.fs);
        chk("d_hsync", hsync_d, qd[LD].hs);
        chk("d_vsync", vsync_d, qd[LD].vs);
        chk("d_red", red_d, exp_rgb_d[11:8]);
        chk("d_green", green_d, exp_rgb_d[7:4]);
        chk("d_blue", blue_d, exp_rgb_d[3:0]);
        e = rs(run_s, k_s);
        chk("s_req", req_s, e.act);
        chk("s_xpos", xpos_s, e.x);
        chk("s_ypos", ypos_s, e.y);
        chk("s_frame_start", frame_start_s, e.fs);
        chk("s_hsync", hsync_s, qs[LS].hs);
        chk("s_vsync", vsync_s, qs[LS].vs);
        chk("s_red", red_s, exp_rgb_s[11:8]);
        chk("s_green", green_s, exp_rgb_s[7:4]);
        chk("s_blue", blue_s, exp_rgb_s[3:0]);
      end
    end
  end

  int cur_d = 0, cur_s = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go_d(input int c);
    tick(c - cur_d);
    cur_d = c;
  endtask

  task automatic go_s(input int c);
    tick(c - cur_s);
    cur_s = c;
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    int nz, nfs;
    tick(3);
    rst_d = 1'b0; rst_s = 1'b0;
    tick(2);
    @(negedge clk);
    chk("rst_req", req_d, 32'd0);
    chk("rst_hsync_d", hsync_d, 32'd1);
    chk("rst_vsync_d", vsync_d, 32'd1);
    chk("rst_red_d", red_d, 32'd0);
    chk("rst_hsync_s", hsync_s, 32'd0);

    en_d = 1'b1;
    tick(1); cur_d = 0;
    @(negedge clk);
    chk("d_fs_first", frame_start_d, 32'd1);
    chk("d_x_first", xpos_d, 32'd0);
    go_d(658);  @(negedge clk); chk("d_hs_658", hsync_d, 32'd1);
    go_d(659);  @(negedge clk); chk("d_hs_659", hsync_d, 32'd0);
    go_d(754);  @(negedge clk); chk("d_hs_754", hsync_d, 32'd0);
    go_d(755);  @(negedge clk); chk("d_hs_755", hsync_d, 32'd1);
    go_d(2417); @(negedge clk);
    chk("d_px_req", req_d, 32'd1);
    chk("d_px_x", xpos_d, 32'd17);
    chk("d_px_y", ypos_d, 32'd3);
    go_d(2420); @(negedge clk);
    chk("d_px_r", red_d, 32'd1);
    chk("d_px_g", green_d, 32'd3);
    chk("d_px_b", blue_d, 32'd5);
    go_d(2700); rst_d = 1'b1; @(negedge clk);
    chk("d_pre_rst_x", xpos_d, 32'd300);
    go_d(2701); rst_d = 1'b0; @(negedge clk);
    chk("d_post_rst_req", req_d, 32'd0);
    chk("d_post_rst_fs", frame_start_d, 32'd0);
    chk("d_post_rst_hs", hsync_d, 32'd1);
    go_d(2702); @(negedge clk);
    chk("d_restart_fs", frame_start_d, 32'd1);

    en_s = 1'b1;
    tick(1); cur_s = 0;
    nz = 0;
    for (int c = 0; c < 120; c++) begin
      if (c > 0) go_s(c);
      @(negedge clk);
      if (red_s != 4'h0) nz++;
      case (c)
        0:       chk("s_fs_first", frame_start_s, 32'd1);
        11:      chk("s_hs_11", hsync_s, 32'd0);
        12:      chk("s_hs_12", hsync_s, 32'd1);
        14:      chk("s_hs_14", hsync_s, 32'd1);
        15:      chk("s_hs_15", hsync_s, 32'd0);
        76:      chk("s_vs_76", vsync_s, 32'd0);
        77:      chk("s_vs_77", vsync_s, 32'd1);
        106:     chk("s_vs_106", vsync_s, 32'd1);
        107:     chk("s_vs_107", vsync_s, 32'd0);
        default: ;
      endcase
    end
    chk("s_rgb_pixels", nz, 32'd32);

    nfs = 0;
    for (int c = 120; c <= 250; c++) begin
      go_s(c);
      if (c == 130) en_s = 1'b0;
      else if (c == 150) en_s = 1'b1;
      else if (c == 160) en_s = 1'b0;
      @(negedge clk);
      if (c == 120) chk("s_fs_period", frame_start_s, 32'd1);
      else if (frame_start_s) nfs++;
      if (c == 240) chk("s_idle_req", req_s, 32'd0);
      if (c == 242) begin
        chk("s_drain_hs", hsync_s, 32'd0);
        chk("s_drain_vs", vsync_s, 32'd0);
        chk("s_drain_red", red_s, 32'd0);
      end
    end
    chk("s_extra_fs", nfs, 32'd0);

    go_s(260); en_s = 1'b1;
    go_s(261); @(negedge clk);
    chk("s_restart_fs", frame_start_s, 32'd1);
    go_s(262); @(negedge clk);
    chk("s_restart_x", xpos_s, 32'd1);

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
